// File: rtl/hermes_periph_port_mux.sv
// Shares one Hermes boundary port among N_PERIPH peripherals.
// Outbound: packet-level round-robin arbitration onto the NoC port.
// Inbound: header channel-field demux, with invalid/gated packets drained and counted.
module hermes_periph_port_mux #(
  parameter int unsigned         N_PERIPH     = 2,
  parameter int unsigned         FLIT_SIZE    = 32,
  parameter logic [N_PERIPH-1:0] RELEASE_MASK = '0,
  parameter int unsigned         CH_LSB       = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               release_i,
  input  logic [N_PERIPH-1:0]                periph_rx_i,
  output logic [N_PERIPH-1:0]                periph_credit_o,
  input  logic [N_PERIPH-1:0][FLIT_SIZE-1:0] periph_data_i,
  output logic [N_PERIPH-1:0]                periph_tx_o,
  input  logic [N_PERIPH-1:0]                periph_credit_i,
  output logic [N_PERIPH-1:0][FLIT_SIZE-1:0] periph_data_o,
  output logic                               noc_tx_o,
  input  logic                               noc_credit_i,
  output logic [FLIT_SIZE-1:0]               noc_data_o,
  input  logic                               noc_rx_i,
  output logic                               noc_credit_o,
  input  logic [FLIT_SIZE-1:0]               noc_data_i,
  output logic [15:0]                        drop_cnt_o
);

  localparam int unsigned CW = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  typedef logic [CW-1:0] ch_t;

  typedef enum logic [1:0] {OIdle, OHdr, OSize, OPay} o_state_e;
  typedef enum logic [2:0] {IIdle, IFwdSize, IFwdPay, IDropSize, IDropPay} i_state_e;

  o_state_e             o_state_q, o_state_d;
  i_state_e             i_state_q, i_state_d;
  ch_t                  grant_q, grant_d;
  ch_t                  ptr_q, ptr_d;
  ch_t                  ch_q, ch_d;
  logic [FLIT_SIZE-1:0] o_cnt_q, o_cnt_d;
  logic [FLIT_SIZE-1:0] i_cnt_q, i_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 rst_done_q;

  logic [N_PERIPH-1:0] eligible;
  ch_t                 pick;
  ch_t                 ch_hdr;
  logic                hdr_ok;
  logic                hdr_credit;
  logic                o_xfer;
  logic                i_xfer;
  logic [15:0]         drop_inc;

  assign eligible   = periph_rx_i & (~RELEASE_MASK | {N_PERIPH{release_i}});
  assign ch_hdr     = noc_data_i[CH_LSB +: CW];
  assign drop_inc   = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  assign drop_cnt_o = drop_cnt_q;

  // Round-robin pick: eligible channel with the smallest wrapped distance from the pointer.
  always_comb begin
    int unsigned best_off;
    int unsigned off;
    int unsigned ptr_ext;
    ptr_ext  = 32'(ptr_q);
    best_off = N_PERIPH;
    off      = 0;
    pick     = ptr_q;
    for (int unsigned c = 0; c < N_PERIPH; c++) begin
      off = (c >= ptr_ext) ? c - ptr_ext : c + N_PERIPH - ptr_ext;
      if (eligible[c] && off < best_off) begin
        best_off = off;
        pick     = ch_t'(c);
      end
    end
  end

  // Inbound header decode: channel in range and not held back by release gating.
  always_comb begin
    hdr_ok     = 1'b0;
    hdr_credit = 1'b0;
    for (int unsigned c = 0; c < N_PERIPH; c++) begin
      if (32'(ch_hdr) == c) begin
        hdr_ok     = !RELEASE_MASK[c] || release_i;
        hdr_credit = periph_credit_i[c];
      end
    end
  end

  // Outbound FSM next-state and combinational flit path from the granted channel.
  always_comb begin
    o_state_d       = o_state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    o_cnt_d         = o_cnt_q;
    noc_tx_o        = 1'b0;
    noc_data_o      = '0;
    periph_credit_o = '0;
    o_xfer          = 1'b0;
    unique case (o_state_q)
      OIdle: begin
        if (|eligible) begin
          grant_d   = pick;
          o_state_d = OHdr;
        end
      end
      default: begin
        noc_tx_o                 = periph_rx_i[grant_q];
        noc_data_o               = periph_data_i[grant_q];
        periph_credit_o[grant_q] = noc_credit_i;
        o_xfer                   = periph_rx_i[grant_q] && noc_credit_i;
      end
    endcase
    if (o_xfer) begin
      unique case (o_state_q)
        OHdr: o_state_d = OSize;
        OSize: begin
          o_cnt_d = noc_data_o;
          if (noc_data_o == '0) begin
            o_state_d = OIdle;
            // Zero-payload packets still rotate the pointer so nobody is starved.
            ptr_d     = (32'(grant_q) == N_PERIPH - 1) ? '0 : grant_q + ch_t'(1);
          end else begin
            o_state_d = OPay;
          end
        end
        OPay: begin
          o_cnt_d = o_cnt_q - FLIT_SIZE'(1);
          if (o_cnt_q == FLIT_SIZE'(1)) begin
            o_state_d = OIdle;
            ptr_d     = (32'(grant_q) == N_PERIPH - 1) ? '0 : grant_q + ch_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Inbound FSM next-state, credit back to the NoC and per-channel valid.
  always_comb begin
    i_state_d    = i_state_q;
    ch_d         = ch_q;
    i_cnt_d      = i_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    noc_credit_o = 1'b0;
    periph_tx_o  = '0;
    i_xfer       = 1'b0;
    // Credit is withheld until the first cycle after reset release.
    if (rst_done_q) begin
      unique case (i_state_q)
        IIdle: begin
          if (hdr_ok) begin
            noc_credit_o        = hdr_credit;
            periph_tx_o[ch_hdr] = noc_rx_i;
          end else begin
            noc_credit_o = 1'b1;
          end
        end
        IFwdSize, IFwdPay: begin
          noc_credit_o      = periph_credit_i[ch_q];
          periph_tx_o[ch_q] = noc_rx_i;
        end
        default: noc_credit_o = 1'b1;
      endcase
    end
    i_xfer = noc_rx_i && noc_credit_o;
    if (i_xfer) begin
      unique case (i_state_q)
        IIdle: begin
          ch_d      = ch_hdr;
          i_state_d = hdr_ok ? IFwdSize : IDropSize;
        end
        IFwdSize, IDropSize: begin
          i_cnt_d = noc_data_i;
          if (noc_data_i == '0) begin
            i_state_d = IIdle;
            if (i_state_q == IDropSize) drop_cnt_d = drop_inc;
          end else begin
            i_state_d = (i_state_q == IFwdSize) ? IFwdPay : IDropPay;
          end
        end
        default: begin
          i_cnt_d = i_cnt_q - FLIT_SIZE'(1);
          if (i_cnt_q == FLIT_SIZE'(1)) begin
            i_state_d = IIdle;
            if (i_state_q == IDropPay) drop_cnt_d = drop_inc;
          end
        end
      endcase
    end
  end

  // Inbound data fans out to every channel; only periph_tx_o qualifies it.
  always_comb begin
    for (int unsigned c = 0; c < N_PERIPH; c++) begin
      periph_data_o[c] = rst_done_q ? noc_data_i : '0;
    end
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_state_q  <= OIdle;
      i_state_q  <= IIdle;
      grant_q    <= '0;
      ptr_q      <= '0;
      ch_q       <= '0;
      o_cnt_q    <= '0;
      i_cnt_q    <= '0;
      drop_cnt_q <= '0;
      rst_done_q <= 1'b0;
    end else begin
      o_state_q  <= o_state_d;
      i_state_q  <= i_state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      o_cnt_q    <= o_cnt_d;
      i_cnt_q    <= i_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rst_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hermes_periph_port_mux.sv
// Directed + randomized bench for hermes_periph_port_mux.
// dut: N_PERIPH=2 with channel 1 release-gated; dut3: N_PERIPH=3 for out-of-range channel drops.
module tb_hermes_periph_port_mux;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic release_i = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       p_rx, p_cred_o, p_tx, p_cred_i;
  logic [1:0][31:0] p_data_i, p_data_o;
  logic             n_tx, n_cred_i, n_rx, n_cred_o;
  logic [31:0]      n_data_o, n_data_i;
  logic [15:0]      drop;

  logic [2:0]       t_p_rx, t_p_cred_o, t_p_tx, t_p_cred_i;
  logic [2:0][31:0] t_p_data_i, t_p_data_o;
  logic             t_n_tx, t_n_cred_i, t_n_rx, t_n_cred_o;
  logic [31:0]      t_n_data_o, t_n_data_i;
  logic [15:0]      t_drop;

  hermes_periph_port_mux #(
    .N_PERIPH(2), .FLIT_SIZE(32), .RELEASE_MASK(2'b10), .CH_LSB(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .release_i(release_i),
    .periph_rx_i(p_rx), .periph_credit_o(p_cred_o), .periph_data_i(p_data_i),
    .periph_tx_o(p_tx), .periph_credit_i(p_cred_i), .periph_data_o(p_data_o),
    .noc_tx_o(n_tx), .noc_credit_i(n_cred_i), .noc_data_o(n_data_o),
    .noc_rx_i(n_rx), .noc_credit_o(n_cred_o), .noc_data_i(n_data_i),
    .drop_cnt_o(drop)
  );

  hermes_periph_port_mux #(
    .N_PERIPH(3), .FLIT_SIZE(32), .RELEASE_MASK(3'b000), .CH_LSB(16)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .release_i(release_i),
    .periph_rx_i(t_p_rx), .periph_credit_o(t_p_cred_o), .periph_data_i(t_p_data_i),
    .periph_tx_o(t_p_tx), .periph_credit_i(t_p_cred_i), .periph_data_o(t_p_data_o),
    .noc_tx_o(t_n_tx), .noc_credit_i(t_n_cred_i), .noc_data_o(t_n_data_o),
    .noc_rx_i(t_n_rx), .noc_credit_o(t_n_cred_o), .noc_data_i(t_n_data_i),
    .drop_cnt_o(t_drop)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] src0[$], src1[$], in_src[$];
  logic [31:0] got_out[$], got_ch0[$], got_ch1[$];
  logic [31:0] pkt[$], exp_q[$], exp0[$];
  logic        s_n_tx, s_ncred;
  logic [31:0] s_n_data;
  logic [1:0]  s_pcred, s_ptx;
  int          ptr, sel, ndrop, cyc, ch, sz_one;
  int          nxt[2];
  int          sz[2][4];
  logic [31:0] fl[6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet: header carries channel at bit 16 and an id; payload flits are numbered.
  task automatic make_pkt(input int c, input int id, input int s);
    pkt.delete();
    pkt.push_back(32'hA000_0ACE | (32'(id & 255) << 20) | (32'(c) << 16));
    pkt.push_back(32'(s));
    for (int k = 0; k < s; k++)
      pkt.push_back(32'hD000_0000 | (32'(id & 255) << 20) | (32'(c) << 16) | 32'(k));
  endtask

  task automatic drive();
    p_rx[0]     = src0.size() > 0;
    p_data_i[0] = (src0.size() > 0) ? src0[0] : 32'h0;
    p_rx[1]     = src1.size() > 0;
    p_data_i[1] = (src1.size() > 0) ? src1[0] : 32'h0;
    n_rx        = in_src.size() > 0;
    n_data_i    = (in_src.size() > 0) ? in_src[0] : 32'h0;
  endtask

  // Sample at the falling edge, log completed handshakes, then advance sources.
  task automatic tick();
    @(negedge clk);
    s_n_tx = n_tx; s_n_data = n_data_o; s_pcred = p_cred_o; s_ptx = p_tx; s_ncred = n_cred_o;
    if (n_tx && n_cred_i) got_out.push_back(n_data_o);
    if (p_rx[0] && p_cred_o[0]) void'(src0.pop_front());
    if (p_rx[1] && p_cred_o[1]) void'(src1.pop_front());
    if (p_tx[0] && p_cred_i[0]) got_ch0.push_back(p_data_o[0]);
    if (p_tx[1] && p_cred_i[1]) got_ch1.push_back(p_data_o[1]);
    if (n_rx && n_cred_o) void'(in_src.pop_front());
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    src0.delete(); src1.delete(); in_src.delete();
    got_out.delete(); got_ch0.delete(); got_ch1.delete();
    p_cred_i = 2'b00; n_cred_i = 1'b0;
    drive();
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    p_rx = '0; p_data_i = '0; p_cred_i = 2'b11; n_cred_i = 1'b0;
    n_rx = 1'b1; n_data_i = 32'hFFFF_FFFF;
    t_p_rx = '0; t_p_data_i = '0; t_p_cred_i = '0; t_n_cred_i = 1'b0;
    t_n_rx = 1'b0; t_n_data_i = '0;

    // Reset state, with inbound stimulus that would otherwise raise credit.
    @(negedge clk);
    @(negedge clk);
    check("rst_noc_tx", 32'(n_tx), 0);
    check("rst_noc_data", n_data_o, 0);
    check("rst_pcred", 32'(p_cred_o), 0);
    check("rst_ptx", 32'(p_tx), 0);
    check("rst_pdata0", p_data_o[0], 0);
    check("rst_pdata1", p_data_o[1], 0);
    check("rst_noc_credit", 32'(n_cred_o), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_drop3", 32'(t_drop), 0);
    check("rst_t_tx", 32'(t_n_tx), 0);
    rst_ni = 1'b1;
    #1;
    check("rel_credit_hold", 32'(n_cred_o), 0);
    @(posedge clk);
    #1;
    check("rel_credit_up", 32'(n_cred_o), 1);
    n_rx = 1'b0;

    // Single outbound packet from ch0: bubble then 5 flits in order.
    do_reset();
    n_cred_i = 1'b1;
    make_pkt(0, 1, 3);
    foreach (pkt[i]) src0.push_back(pkt[i]);
    drive();
    tick();
    check("bubble", 32'(s_n_tx), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("single_valid", 32'(s_n_tx), 1);
      check("single_pcred", 32'(s_pcred), 32'h1);
      check("single_data", s_n_data, pkt[k]);
    end
    tick();
    check("single_after", 32'(s_n_tx), 0);
    check("single_count", got_out.size(), 5);

    // Round robin under random backpressure against a packet-order model.
    do_reset();
    release_i = 1'b1;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 4; k++) begin
        sz[c][k] = int'($urandom_range(1, 3));
        make_pkt(c, c * 8 + k, sz[c][k]);
        foreach (pkt[i]) if (c == 0) src0.push_back(pkt[i]); else src1.push_back(pkt[i]);
      end
    exp_q.delete();
    ptr = 0; nxt[0] = 0; nxt[1] = 0;
    for (int p = 0; p < 8; p++) begin
      sel = -1;
      for (int off = 0; off < 2; off++)
        if (sel < 0 && nxt[(ptr + off) % 2] < 4) sel = (ptr + off) % 2;
      make_pkt(sel, sel * 8 + nxt[sel], sz[sel][nxt[sel]]);
      foreach (pkt[i]) exp_q.push_back(pkt[i]);
      nxt[sel]++;
      ptr = (sel + 1) % 2;
    end
    drive();
    for (cyc = 0; cyc < 400 && got_out.size() < exp_q.size(); cyc++) begin
      n_cred_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rr_count", got_out.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("rr_flit", (i < got_out.size()) ? got_out[i] : 32'hx, exp_q[i]);

    // Release gating: ch1 held off until release, packet survives release dropping.
    do_reset();
    release_i = 1'b0;
    n_cred_i = 1'b1;
    make_pkt(1, 7, 3);
    foreach (pkt[i]) src1.push_back(pkt[i]);
    drive();
    repeat (6) tick();
    check("gate_hold", got_out.size(), 0);
    check("gate_pcred", 32'(s_pcred), 0);
    release_i = 1'b1;
    for (cyc = 0; cyc < 20 && got_out.size() < 3; cyc++) tick();
    release_i = 1'b0;
    for (cyc = 0; cyc < 20 && got_out.size() < 5; cyc++) tick();
    check("gate_count", got_out.size(), 5);
    for (int i = 0; i < 5; i++)
      check("gate_flit", (i < got_out.size()) ? got_out[i] : 32'hx, pkt[i]);

    // Inbound to ch1 with toggling credit; credit to NoC must mirror it.
    do_reset();
    release_i = 1'b1;
    make_pkt(1, 3, 2);
    foreach (pkt[i]) in_src.push_back(pkt[i]);
    drive();
    for (cyc = 0; cyc < 20 && in_src.size() > 0; cyc++) begin
      p_cred_i = {cyc[0] == 1'b0, 1'b1};
      tick();
      check("in_mirror", 32'(s_ncred), 32'(p_cred_i[1]));
      check("in_ch0_quiet", 32'(s_ptx[0]), 0);
    end
    check("in_ch1_count", got_ch1.size(), 4);
    for (int i = 0; i < 4; i++)
      check("in_ch1_flit", (i < got_ch1.size()) ? got_ch1[i] : 32'hx, pkt[i]);
    check("in_ch0_count", got_ch0.size(), 0);
    check("in_drop", 32'(drop), 0);

    // Random inbound stream with ch1 gated: ch0 delivered, ch1 dropped and counted.
    release_i = 1'b0;
    got_ch0.delete(); got_ch1.delete(); exp0.delete();
    ndrop = 0;
    for (int p = 0; p < 6; p++) begin
      ch = (p == 0) ? 1 : int'($urandom_range(0, 1));
      sz_one = int'($urandom_range(0, 3));
      make_pkt(ch, 20 + p, sz_one);
      foreach (pkt[i]) begin
        in_src.push_back(pkt[i]);
        if (ch == 0) exp0.push_back(pkt[i]);
      end
      if (ch == 1) ndrop++;
    end
    drive();
    for (cyc = 0; cyc < 400 && in_src.size() > 0; cyc++) begin
      p_cred_i = 2'($urandom_range(0, 3));
      tick();
    end
    p_cred_i = 2'b00;
    tick();
    check("rnd_ch0_count", got_ch0.size(), exp0.size());
    for (int i = 0; i < exp0.size(); i++)
      check("rnd_ch0_flit", (i < got_ch0.size()) ? got_ch0[i] : 32'hx, exp0[i]);
    check("rnd_ch1_count", got_ch1.size(), 0);
    check("rnd_drop", 32'(drop), 32'(ndrop));

    // Zero-size packet, then reset in the middle of the next packet's payload.
    n_cred_i = 1'b1;
    make_pkt(0, 9, 0);
    exp_q.delete();
    foreach (pkt[i]) begin
      src0.push_back(pkt[i]);
      exp_q.push_back(pkt[i]);
    end
    make_pkt(0, 10, 3);
    foreach (pkt[i]) src0.push_back(pkt[i]);
    drive();
    for (cyc = 0; cyc < 40 && got_out.size() < 5; cyc++) tick();
    check("s0_hdr", (got_out.size() > 0) ? got_out[0] : 32'hx, exp_q[0]);
    check("s0_size", (got_out.size() > 1) ? got_out[1] : 32'hx, exp_q[1]);
    check("s0_next_hdr", (got_out.size() > 2) ? got_out[2] : 32'hx, pkt[0]);
    rst_ni = 1'b0;
    #1;
    check("midrst_tx", 32'(n_tx), 0);
    check("midrst_pcred", 32'(p_cred_o), 0);
    check("midrst_ncred", 32'(n_cred_o), 0);
    check("midrst_drop", 32'(drop), 0);
    check("midrst_ptx", 32'(p_tx), 0);
    do_reset();
    release_i = 1'b1;
    n_cred_i = 1'b1;
    make_pkt(1, 11, 2);
    foreach (pkt[i]) src1.push_back(pkt[i]);
    drive();
    for (cyc = 0; cyc < 30 && got_out.size() < 4; cyc++) tick();
    check("clean_count", got_out.size(), 4);
    for (int i = 0; i < 4; i++)
      check("clean_flit", (i < got_out.size()) ? got_out[i] : 32'hx, pkt[i]);

    // N_PERIPH=3: channel 3 is out of range and must be drained and counted.
    release_i = 1'b0;
    t_p_cred_i = 3'b111;
    check("t_drop0", 32'(t_drop), 0);
    fl[0] = 32'h0003_0000; fl[1] = 32'd4;
    for (int k = 0; k < 4; k++) fl[k + 2] = 32'hC0DE_0000 | 32'(k);
    for (int k = 0; k < 6; k++) begin
      t_n_rx = 1'b1;
      t_n_data_i = fl[k];
      @(negedge clk);
      check("t_drop_credit", 32'(t_n_cred_o), 1);
      check("t_drop_quiet", 32'(t_p_tx), 0);
      @(posedge clk);
      #1;
    end
    t_n_rx = 1'b0;
    t_n_data_i = '0;
    check("t_drop1", 32'(t_drop), 1);
    check("t_out_idle", 32'(t_p_cred_o), 0);
    t_n_rx = 1'b1;
    t_n_data_i = 32'h0002_0000;
    @(negedge clk);
    check("t_ch2_hdr", 32'(t_p_tx), 32'h4);
    @(posedge clk);
    #1;
    t_n_data_i = 32'h0;
    @(negedge clk);
    check("t_ch2_size", 32'(t_p_tx), 32'h4);
    check("t_ch2_data", t_p_data_o[2], 0);
    @(posedge clk);
    #1;
    t_n_rx = 1'b0;
    check("t_drop_still1", 32'(t_drop), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
